// File: rtl/pq_grant_drain_pkg.sv
// pq_grant_drain_pkg
//   Shared types and constants for the grant-drain block and its helpers.
//   drain_state_e : IDLE / DRAIN state encoding of the drain controller.
//   PQ_N_DEFAULT  : default request-vector width.
package pq_grant_drain_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } drain_state_e;

  localparam int PQ_N_DEFAULT = 14;

endpackage

// File: rtl/pq_grant_drain_onehot_enc.sv
// onehot_enc
//   Combinational one-hot to binary encoder.
//   Ports:
//     i_onehot [N-1:0]     : one-hot (or zero) input
//     o_idx    [IDX_W-1:0] : binary index of the set bit, zero when no bit set
module onehot_enc
  import pq_grant_drain_pkg::*;
#(
  parameter int N     = PQ_N_DEFAULT,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     i_onehot,
  output logic [IDX_W-1:0] o_idx
);

  // OR of the indices of all set bits; exact for a one-hot input.
  always_comb begin
    o_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (i_onehot[i]) begin
        o_idx = o_idx | IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/pq_grant_drain_pq.sv
// pq
//   Lowest-index priority qualifier: keeps only the lowest set bit of the
//   request vector.
//   Ports:
//     i_req [N-1:0] : request vector
//     o_gnt [N-1:0] : one-hot lowest set bit of i_req, zero when i_req==0
module pq
  import pq_grant_drain_pkg::*;
#(
  parameter int N = PQ_N_DEFAULT
) (
  input  logic [N-1:0] i_req,
  output logic [N-1:0] o_gnt
);

  // Two's complement isolates the lowest set bit: x & -x.
  assign o_gnt = i_req & (-i_req);

endmodule

// File: rtl/pq_grant_drain.sv
// pq_grant_drain
//   Latches a batch of requests and drains it one grant per cycle, lowest
//   index first, onto a valid/ready sink.
//   Ports:
//     CLK, nRST                : clock, asynchronous active-low reset
//     req_valid/req_vec/req_ready : upstream batch handshake
//     flush                    : synchronous abort of the current batch
//     grant_valid/grant_ready  : downstream grant handshake
//     grant_onehot, grant_idx  : current grant as one-hot and binary index
//     grant_last               : current grant is the final bit of the batch
//     busy                     : a batch is in progress
//
//   state    | meaning
//   ---------+---------------------------------------------
//   ST_IDLE  | no batch held, ready for a new request vector
//   ST_DRAIN | pending holds the remaining bits of a batch
module pq_grant_drain
  import pq_grant_drain_pkg::*;
#(
  parameter int N     = PQ_N_DEFAULT,
  parameter int IDX_W = $clog2(N)
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             req_valid,
  input  logic [N-1:0]     req_vec,
  output logic             req_ready,
  input  logic             flush,
  output logic             grant_valid,
  output logic [N-1:0]     grant_onehot,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_last,
  input  logic             grant_ready,
  output logic             busy
);

  localparam logic [N-1:0] ONE = N'(1);

  drain_state_e     r_state;
  logic [N-1:0]     r_pending;

  logic [N-1:0]     w_onehot;
  logic [N-1:0]     w_rest;
  logic             w_fire_g;
  logic             w_fire_r;
  logic             w_req_nz;

  pq #(.N(N)) u_pq (
    .i_req (r_pending),
    .o_gnt (w_onehot)
  );

  onehot_enc #(.N(N), .IDX_W(IDX_W)) u_enc (
    .i_onehot (w_onehot),
    .o_idx    (grant_idx)
  );

  // Bits left after the current grant; zero means this grant is the last.
  assign w_rest       = r_pending & (r_pending - ONE);

  assign grant_onehot = w_onehot;
  assign grant_valid  = (r_state == ST_DRAIN);
  assign busy         = (r_state == ST_DRAIN);
  assign grant_last   = grant_valid && (w_rest == '0);

  assign w_fire_g     = grant_valid & grant_ready;
  // Accepting on the last consumed grant lets batches run back to back.
  assign req_ready    = (r_state == ST_IDLE) | (w_fire_g & grant_last);
  assign w_fire_r     = req_valid & req_ready;
  assign w_req_nz     = (req_vec != '0);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state   <= ST_IDLE;
      r_pending <= '0;
    end else if (flush) begin
      // Abort wins; a request offered in the same cycle is not captured.
      r_state   <= ST_IDLE;
      r_pending <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_fire_r && w_req_nz) begin
            r_pending <= req_vec;
            r_state   <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (w_fire_g) begin
            if (!grant_last) begin
              r_pending <= r_pending & ~w_onehot;
            end else if (w_fire_r && w_req_nz) begin
              r_pending <= req_vec;
            end else begin
              r_pending <= '0;
              r_state   <= ST_IDLE;
            end
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_pending <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pq_grant_drain.sv
module tb_pq_grant_drain;

  localparam int N     = 14;
  localparam int IDX_W = 4;

  logic             CLK;
  logic             nRST;
  logic             req_valid;
  logic [N-1:0]     req_vec;
  logic             req_ready;
  logic             flush;
  logic             grant_valid;
  logic [N-1:0]     grant_onehot;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_last;
  logic             grant_ready;
  logic             busy;

  int total;
  int bad;

  pq_grant_drain #(.N(N), .IDX_W(IDX_W)) dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .req_valid    (req_valid),
    .req_vec      (req_vec),
    .req_ready    (req_ready),
    .flush        (flush),
    .grant_valid  (grant_valid),
    .grant_onehot (grant_onehot),
    .grant_idx    (grant_idx),
    .grant_last   (grant_last),
    .grant_ready  (grant_ready),
    .busy         (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // Checks a presented grant: validity, index, one-hot, last flag, busy.
  task automatic chk_grant(input string tag, input int idx, input logic last);
    logic [N-1:0] oh;
    oh = '0;
    oh[idx] = 1'b1;
    chk({tag, "_vld"},  32'(grant_valid),  32'd1);
    chk({tag, "_idx"},  32'(grant_idx),    32'(idx));
    chk({tag, "_oh"},   32'(grant_onehot), 32'(oh));
    chk({tag, "_last"}, 32'(grant_last),   32'(last));
    chk({tag, "_busy"}, 32'(busy),         32'd1);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_vld"},  32'(grant_valid),  32'd0);
    chk({tag, "_oh"},   32'(grant_onehot), 32'd0);
    chk({tag, "_idx"},  32'(grant_idx),    32'd0);
    chk({tag, "_last"}, 32'(grant_last),   32'd0);
    chk({tag, "_busy"}, 32'(busy),         32'd0);
    chk({tag, "_rrdy"}, 32'(req_ready),    32'd1);
  endtask

  // Continuous invariants and hold-stability, sampled on the falling edge.
  logic             p_hold;
  logic [N-1:0]     p_oh;
  logic [IDX_W-1:0] p_idx;
  logic             p_last;

  initial p_hold = 1'b0;

  always @(negedge CLK) begin
    if (nRST) begin
      int pos;
      pos = 0;
      for (int i = 0; i < N; i++) if (grant_onehot[i]) pos = i;
      chk("inv_onehot0", 32'($onehot0(grant_onehot)), 32'd1);
      chk("inv_zero_iff_idle", 32'(grant_onehot != '0), 32'(grant_valid));
      chk("inv_idx_pos", 32'(grant_idx), 32'(pos));
      if (p_hold) begin
        chk("hold_oh",   32'(grant_onehot), 32'(p_oh));
        chk("hold_idx",  32'(grant_idx),    32'(p_idx));
        chk("hold_last", 32'(grant_last),   32'(p_last));
        chk("hold_vld",  32'(grant_valid),  32'd1);
      end
      p_hold = grant_valid & ~grant_ready & ~flush;
      p_oh   = grant_onehot;
      p_idx  = grant_idx;
      p_last = grant_last;
    end else begin
      p_hold = 1'b0;
    end
  end

  initial begin
    total       = 0;
    bad         = 0;
    nRST        = 1'b0;
    req_valid   = 1'b0;
    req_vec     = '0;
    flush       = 1'b0;
    grant_ready = 1'b0;

    #12;
    chk_idle("rst");
    #1 nRST = 1'b1;
    tick;

    // Basic batch 0,2,5 with grant_ready held high.
    req_valid = 1'b1; req_vec = 14'h0025; grant_ready = 1'b1;
    #1 chk("t1_rrdy_idle", 32'(req_ready), 32'd1);
    tick;
    req_valid = 1'b0; req_vec = '0;
    #1 chk_grant("t1_g0", 0, 1'b0);
    chk("t1_rrdy_g0", 32'(req_ready), 32'd0);
    tick;
    chk_grant("t1_g2", 2, 1'b0);
    tick;
    chk_grant("t1_g5", 5, 1'b1);
    chk("t1_rrdy_g5", 32'(req_ready), 32'd1);
    tick;
    chk_idle("t1_end");

    // Same batch with grant_ready pattern 1,0,0,1,1.
    req_valid = 1'b1; req_vec = 14'h0025; grant_ready = 1'b1;
    tick;
    req_valid = 1'b0; req_vec = '0;
    #1 chk_grant("t2_g0", 0, 1'b0);
    tick;
    grant_ready = 1'b0;
    #1 chk_grant("t2_h0", 2, 1'b0);
    chk("t2_oh_h0", 32'(grant_onehot), 32'h0004);
    tick;
    chk_grant("t2_h1", 2, 1'b0);
    chk("t2_oh_h1", 32'(grant_onehot), 32'h0004);
    chk("t2_rrdy_h1", 32'(req_ready), 32'd0);
    tick;
    grant_ready = 1'b1;
    #1 chk_grant("t2_g2", 2, 1'b0);
    tick;
    chk_grant("t2_g5", 5, 1'b1);
    tick;
    chk_idle("t2_end");

    // Back-to-back batches A=0x0003 then B=0x2000.
    req_valid = 1'b1; req_vec = 14'h0003; grant_ready = 1'b1;
    tick;
    req_vec = 14'h2000;
    #1 chk_grant("t3_a0", 0, 1'b0);
    chk("t3_rrdy_a0", 32'(req_ready), 32'd0);
    tick;
    chk_grant("t3_a1", 1, 1'b1);
    chk("t3_rrdy_a1", 32'(req_ready), 32'd1);
    tick;
    req_valid = 1'b0; req_vec = '0;
    #1 chk_grant("t3_b13", 13, 1'b1);
    tick;
    chk_idle("t3_end");

    // Zero request vector accepted in IDLE and dropped.
    req_valid = 1'b1; req_vec = '0;
    #1 chk("t4_rrdy", 32'(req_ready), 32'd1);
    tick;
    req_valid = 1'b0;
    #1 chk_idle("t4_after");
    tick;
    chk_idle("t4_after2");

    // All-ones batch, flushed concurrently with the 4th grant.
    req_valid = 1'b1; req_vec = 14'h3FFF; grant_ready = 1'b1;
    tick;
    req_valid = 1'b0; req_vec = '0;
    #1 chk_grant("t5_g0", 0, 1'b0);
    tick;
    chk_grant("t5_g1", 1, 1'b0);
    tick;
    chk_grant("t5_g2", 2, 1'b0);
    tick;
    flush = 1'b1;
    #1 chk_grant("t5_g3", 3, 1'b0);
    tick;
    chk_idle("t5_flushed");
    // Flush in IDLE: request is offered and req_ready is high, but not captured.
    req_valid = 1'b1; req_vec = 14'h0100;
    #1 chk("t5_rrdy_flush", 32'(req_ready), 32'd1);
    tick;
    flush = 1'b0; req_valid = 1'b0; req_vec = '0;
    #1 chk_idle("t5_nocap");
    req_valid = 1'b1; req_vec = 14'h0100;
    tick;
    req_valid = 1'b0; req_vec = '0;
    #1 chk_grant("t5_g8", 8, 1'b1);
    tick;
    chk_idle("t5_end");

    // Asynchronous reset mid-batch.
    req_valid = 1'b1; req_vec = 14'h0011; grant_ready = 1'b1;
    tick;
    req_valid = 1'b0; req_vec = '0;
    #1 chk_grant("t6_g0", 0, 1'b0);
    tick;
    chk_grant("t6_g4", 4, 1'b1);
    #1 nRST = 1'b0;
    #1 chk_idle("t6_rst");
    #1 nRST = 1'b1;
    tick;
    chk_idle("t6_post");
    tick;
    chk_idle("t6_post2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pq_grant_drain.md
Name: pq_grant_drain

Overview:
- Consumer end of the one-hot priority-qualifier interface.
- Latches an N-bit request vector from an upstream requester.
- Drains it one grant per cycle, lowest index first, to a downstream valid/ready sink.
- Each grant is presented as a one-hot vector plus an encoded index.
- Used wherever a batch of ready entries (e.g. issue queue, LSQ wakeups) must be serialized onto a single port.

Parameters:
- N, 14, width of the request vector / number of requesters.
- IDX_W, $clog2(N), width of the encoded grant index.

Ports:
- CLK  input  1  clock.
- nRST  input  1  asynchronous active-low reset.
- req_valid  input  1  upstream presents req_vec this cycle.
- req_vec  input  N  request batch; bit i = requester i wants service.
- req_ready  output  1  block accepts req_vec this cycle.
- flush  input  1  synchronous abort of the current batch.
- grant_valid  output  1  grant_onehot/grant_idx are valid.
- grant_onehot  output  N  lowest set bit of the pending vector, one-hot.
- grant_idx  output  IDX_W  binary index of grant_onehot.
- grant_last  output  1  current grant is the final bit of the batch.
- grant_ready  input  1  downstream consumes the grant this cycle.
- busy  output  1  a batch is in progress (state DRAIN).

Behaviour:
- Reset and clock: nRST asynchronous, active-low; clock CLK; all state rising-edge.
- Reset values:
  - state=IDLE, pending='0.
  - Outputs: req_ready=1, grant_valid=0, grant_onehot='0, grant_idx='0, grant_last=0, busy=0.
- State register holds IDLE or DRAIN; pending is an N-bit register.
- Combinational outputs from registers only, with no input-to-output path except req_ready:
  - grant_onehot = pending & (~pending + 1).
  - grant_idx = encode(grant_onehot).
  - grant_valid = (state==DRAIN).
  - grant_last = grant_valid && (pending & (pending-1)) == 0.
  - busy = (state==DRAIN).
- fire_g = grant_valid & grant_ready.
- req_ready = (state==IDLE) | (fire_g & grant_last). This gives back-to-back batches with no bubble.
- fire_r = req_valid & req_ready.
- IDLE:
  - fire_r with req_vec!=0: pending<=req_vec, go to DRAIN.
  - fire_r with req_vec==0: accepted and dropped, stay IDLE, no grant issued.
- DRAIN:
  - fire_g and not grant_last: pending <= pending & ~grant_onehot.
  - fire_g and grant_last and fire_r with nonzero req_vec: pending<=req_vec, stay DRAIN.
  - fire_g and grant_last, otherwise: pending<='0, go to IDLE.
  - grant_ready=0: pending, grant_onehot, grant_idx and grant_last must hold stable.
- Latency: a batch accepted at edge T presents its first grant in cycle T+1. Throughput is 1 grant/cycle while grant_ready=1. A batch of k bits drains in exactly k consuming cycles.
- Ordering: strictly ascending index within a batch. Bits of a new batch never merge into the current batch.
- flush:
  - Has priority over everything: next state IDLE, pending<='0.
  - A concurrent fire_g is still a valid consumption by downstream.
  - req_vec is not captured in a flush cycle, although req_ready may be 1.
- Boundary cases:
  - N-bit all-ones batch drains 0..N-1.
  - Single-bit batch: grant_last=1 on its only grant.
  - Bit N-1 alone gives grant_idx=N-1.
  - pending never holds a bit that was not in the accepted req_vec.
- Reset asserted mid-batch: immediate return to reset values; the batch is lost.
- Assertions for the bench:
  - grant_onehot is one-hot or zero; it is zero iff grant_valid=0.
  - grant_idx == position of grant_onehot.
  - Outputs are stable while grant_valid & ~grant_ready.

Decomposition:
- Shared package: no new typedefs required. If the core types package gains a generic N-bit request vector type, reuse it for req_vec/grant_onehot.
- Sub-modules:
  - Instantiate the existing lowest-priority qualifier (pq) for grant_onehot.
  - Add one new combinational sub-module, onehot_enc (parameter N), for grant_idx.
  - The FSM and pending register stay in pq_grant_drain.

Test Plan:
- Reset, then req_vec=14'b00_0000_0010_0101, req_valid=1, grant_ready=1 -> grants idx 0,2,5 in cycles 1,2,3; grant_last=1 only on idx 5; req_ready=1 on cycle 3.
- Same batch with grant_ready toggling 1,0,0,1,1 -> idx 0 consumed; idx 2 held stable for 2 cycles with identical grant_onehot=14'h0004; then idx 2, idx 5.
- Back-to-back: batch A=14'h0003, batch B=14'h2000 held on req_valid -> grants 0, 1(last, B accepted same edge), 13(last); busy never drops between A and B.
- req_vec=0 accepted in IDLE -> grant_valid stays 0, state IDLE, req_ready stays 1.
- All-ones batch 14'h3FFF with flush asserted after 4 grants -> idx 0..3 granted, then grant_valid=0 next cycle, busy=0, new batch 14'h0100 grants idx 8.
- nRST pulsed low mid-batch (after idx 0 of 14'h0011) -> outputs at reset values asynchronously; after release no residual grant of idx 4.
